// File: rtl/pwm_pkg.sv
// Shared constants and parameter checking for the multi-channel PWM block.
package pwm_pkg;

    // Active counting mode, latched once per period.
    localparam logic MODE_EDGE   = 1'b0;
    localparam logic MODE_CENTRE = 1'b1;

    // Counter direction; only centre-aligned mode ever counts down.
    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // True when the parameter set describes a buildable PWM block:
    // the counter must hold PERIOD and every duty value, and the step
    // must be a usable fraction of the range.
    function automatic bit params_legal(input int width, input int period,
                                        input int channels, input int step,
                                        input int duty_rst);
        longint span;
        span = longint'(1) << width;
        return (width >= 1) && (width <= 31) && (period >= 1) &&
               (span > longint'(period)) && (channels >= 1) &&
               (step >= 1) && (step <= period) &&
               (duty_rst >= 0) && (duty_rst <= period);
    endfunction

endpackage

// File: rtl/pwm_btn_edge.sv
// Push-button front end: two-flop synchroniser plus falling-edge detector.
// The strobe is active low, so a press is a high-to-low transition of the
// synchronised level; holding the button yields a single event.
module pwm_btn_edge
    import pwm_pkg::*;
(
    input  logic clkin,
    input  logic reset,
    input  logic btn,
    output logic fall
);

    logic sync1;
    logic sync2;
    logic last;

    // Synchronise the asynchronous strobe and keep the previous level for edge detection.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            last  <= 1'b1;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            last  <= sync2;
        end
    end

    // One-cycle event when the synchronised level drops from 1 to 0.
    assign fall = last & ~sync2;

endmodule

// File: rtl/pwm_multi_duty.sv
// Multi-channel PWM generator with a shared edge/centre-aligned period
// counter. Each channel keeps a button-stepped duty target that is copied
// into the active compare value only at a period boundary, so a period is
// never disturbed by a mid-period change.
module pwm_multi_duty
    import pwm_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PERIOD   = 100,
    parameter int CHANNELS = 2,
    parameter int STEP     = 10,
    parameter int DUTY_RST = 50
) (
    input  logic                      clkin,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       inc,
    input  logic [CHANNELS-1:0]       dec,
    input  logic                      mode,
    output logic [CHANNELS-1:0]       pwm,
    output logic [CHANNELS*WIDTH-1:0] d,
    output logic                      period_start
);

    localparam logic [WIDTH-1:0] CNT_LAST  = WIDTH'(PERIOD - 1);
    localparam logic [WIDTH-1:0] CNT_ZERO  = '0;
    localparam logic [WIDTH-1:0] DUTY_MAX  = WIDTH'(PERIOD);
    localparam logic [WIDTH-1:0] DUTY_INIT = WIDTH'(DUTY_RST);
    localparam logic [WIDTH:0]   STEP_X    = (WIDTH+1)'(STEP);
    localparam logic [WIDTH:0]   PERIOD_X  = (WIDTH+1)'(PERIOD);

    if (!params_legal(WIDTH, PERIOD, CHANNELS, STEP, DUTY_RST)) begin : g_bad_params
        $error("pwm_multi_duty: illegal parameter set");
    end

    logic [WIDTH-1:0] cnt;
    logic             dir;
    logic             act_mode;
    logic             boundary;

    // Last cycle of the period, judged by the rule of the mode currently running.
    always_comb begin
        boundary = 1'b0;
        if (act_mode == MODE_CENTRE) begin
            boundary = (cnt == CNT_ZERO) && (dir == DIR_DOWN);
        end else begin
            boundary = (cnt == CNT_LAST);
        end
    end

    // Shared period counter; centre mode holds the top value one extra cycle while turning.
    always_ff @(posedge clkin) begin
        if (!reset) begin
            cnt          <= '0;
            dir          <= DIR_UP;
            act_mode     <= MODE_EDGE;
            period_start <= 1'b0;
        end else begin
            period_start <= boundary;
            if (boundary) begin
                cnt      <= '0;
                dir      <= DIR_UP;
                act_mode <= mode;
            end else if (dir == DIR_UP) begin
                if (cnt == CNT_LAST) begin
                    dir <= DIR_DOWN;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic             inc_ev;
        logic             dec_ev;
        logic [WIDTH-1:0] target;
        logic [WIDTH-1:0] active;
        logic [WIDTH:0]   sum_x;
        logic [WIDTH:0]   diff_x;
        logic             pwm_q;

        pwm_btn_edge u_inc (
            .clkin (clkin),
            .reset (reset),
            .btn   (inc[c]),
            .fall  (inc_ev)
        );

        pwm_btn_edge u_dec (
            .clkin (clkin),
            .reset (reset),
            .btn   (dec[c]),
            .fall  (dec_ev)
        );

        // One bit wider than the duty so saturation is detected before any wrap.
        always_comb begin
            sum_x  = {1'b0, target} + STEP_X;
            diff_x = {1'b0, target} - STEP_X;
        end

        // Duty target: saturating step up/down; simultaneous inc and dec cancel.
        always_ff @(posedge clkin) begin
            if (!reset) begin
                target <= DUTY_INIT;
            end else if (inc_ev && !dec_ev) begin
                target <= (sum_x > PERIOD_X) ? DUTY_MAX : sum_x[WIDTH-1:0];
            end else if (dec_ev && !inc_ev) begin
                target <= diff_x[WIDTH] ? '0 : diff_x[WIDTH-1:0];
            end
        end

        // Active duty follows the target only at a period boundary.
        always_ff @(posedge clkin) begin
            if (!reset) begin
                active <= DUTY_INIT;
            end else if (boundary) begin
                active <= target;
            end
        end

        // Registered compare keeps the output free of combinational glitches.
        always_ff @(posedge clkin) begin
            if (!reset) begin
                pwm_q <= 1'b0;
            end else begin
                pwm_q <= (cnt < active);
            end
        end

        assign pwm[c]               = pwm_q;
        assign d[c*WIDTH +: WIDTH]  = target;
    end

endmodule

// File: tb/tb_pwm_multi_duty.sv
// Self-checking bench for pwm_multi_duty: a period-position reference model
// checked every cycle, table-driven button vectors, and hand-written
// sequences for saturation, mid-period presses, centre mode and reset.
module tb_pwm_multi_duty;

    localparam int WIDTH    = 8;
    localparam int PERIOD   = 100;
    localparam int CHANNELS = 2;
    localparam int STEP     = 10;
    localparam int DUTY_RST = 50;

    logic                      clkin = 1'b0;
    logic                      reset = 1'b0;
    logic [CHANNELS-1:0]       inc   = '1;
    logic [CHANNELS-1:0]       dec   = '1;
    logic                      mode  = 1'b0;
    logic [CHANNELS-1:0]       pwm;
    logic [CHANNELS*WIDTH-1:0] d;
    logic                      period_start;

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    pwm_multi_duty #(
        .WIDTH    (WIDTH),
        .PERIOD   (PERIOD),
        .CHANNELS (CHANNELS),
        .STEP     (STEP),
        .DUTY_RST (DUTY_RST)
    ) dut (
        .clkin        (clkin),
        .reset        (reset),
        .inc          (inc),
        .dec          (dec),
        .mode         (mode),
        .pwm          (pwm),
        .d            (d),
        .period_start (period_start)
    );

    // Clock and watchdog
    always #5 clkin = ~clkin;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: tracks position t within the period rather than a
    // counter and direction. The counter value seen by the compare is the
    // position in edge mode and a triangle folded at PERIOD in centre mode.
    int m_t;
    int m_amode;
    int m_len;
    bit m_bnd;
    int m_tgt[CHANNELS];
    int m_act[CHANNELS];
    bit m_pwm[CHANNELS];
    bit m_ps;
    bit h_inc[CHANNELS][3];
    bit h_dec[CHANNELS][3];
    bit ev_i;
    bit ev_d;

    function automatic int cnt_at(input int t, input int md);
        if (md == 0) return t;
        return (t < PERIOD) ? t : (2 * PERIOD - 1 - t);
    endfunction

    always @(posedge clkin) begin
        if (!reset) begin
            m_t     = 0;
            m_amode = 0;
            m_ps    = 1'b0;
            for (int c = 0; c < CHANNELS; c++) begin
                m_tgt[c] = DUTY_RST;
                m_act[c] = DUTY_RST;
                m_pwm[c] = 1'b0;
                for (int j = 0; j < 3; j++) begin
                    h_inc[c][j] = 1'b1;
                    h_dec[c][j] = 1'b1;
                end
            end
        end else begin
            m_len = (m_amode == 1) ? 2 * PERIOD : PERIOD;
            m_bnd = (m_t == m_len - 1);
            m_ps  = m_bnd;
            for (int c = 0; c < CHANNELS; c++) begin
                m_pwm[c] = (cnt_at(m_t, m_amode) < m_act[c]);
                // A press sampled low two edges ago after a high sample lands now.
                ev_i = !h_inc[c][1] && h_inc[c][2];
                ev_d = !h_dec[c][1] && h_dec[c][2];
                h_inc[c][2] = h_inc[c][1];
                h_inc[c][1] = h_inc[c][0];
                h_inc[c][0] = inc[c];
                h_dec[c][2] = h_dec[c][1];
                h_dec[c][1] = h_dec[c][0];
                h_dec[c][0] = dec[c];
                if (m_bnd) m_act[c] = m_tgt[c];
                if (ev_i && !ev_d) begin
                    m_tgt[c] = (m_tgt[c] + STEP > PERIOD) ? PERIOD : m_tgt[c] + STEP;
                end else if (ev_d && !ev_i) begin
                    m_tgt[c] = (m_tgt[c] - STEP < 0) ? 0 : m_tgt[c] - STEP;
                end
            end
            if (m_bnd) begin
                m_amode = int'(mode);
                m_t     = 0;
            end else begin
                m_t++;
            end
        end
    end

    // Scoreboard: every cycle, outputs against the model
    always @(negedge clkin) begin
        if (chk_en) begin
            for (int c = 0; c < CHANNELS; c++) begin
                check($sformatf("model_pwm%0d", c), int'(pwm[c]), int'(m_pwm[c]));
                check($sformatf("model_d%0d", c), int'(d[c*WIDTH +: WIDTH]), m_tgt[c]);
            end
            check("model_period_start", int'(period_start), int'(m_ps));
        end
    end

    // Driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clkin);
    endtask

    task automatic wait_ps(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clkin);
            if (period_start) seen = 1'b1;
        end
        check("period_start_within_budget", int'(seen), 1);
    endtask

    task automatic count_high(input int ch, input int n, output int hi);
        hi = 0;
        repeat (n) begin
            @(negedge clkin);
            hi += int'(pwm[ch]);
        end
    endtask

    typedef struct {
        string      name;
        logic [1:0] pi;
        logic [1:0] pd;
        int         hold;
        int         e0;
        int         e1;
    } vec_t;

    vec_t tbl[$];

    task automatic apply_vec(input vec_t v);
        inc = ~v.pi;
        dec = ~v.pd;
        tick(v.hold);
        inc = '1;
        dec = '1;
        tick(5);
        check({v.name, "_d0"}, int'(d[WIDTH-1:0]), v.e0);
        check({v.name, "_d1"}, int'(d[2*WIDTH-1:WIDTH]), v.e1);
    endtask

    task automatic run_table();
        foreach (tbl[i]) apply_vec(tbl[i]);
        tbl.delete();
    endtask

    int hi;
    int ps_cnt;
    int asym;
    bit hs[2*PERIOD];
    int e;

    initial begin
        // Reset then idle
        reset = 1'b0;
        tick(3);
        reset  = 1'b1;
        chk_en = 1'b1;
        check("rst_d0", int'(d[WIDTH-1:0]), 50);
        check("rst_d1", int'(d[2*WIDTH-1:WIDTH]), 50);
        check("rst_pwm", int'(pwm), 0);
        check("rst_period_start", int'(period_start), 0);
        hi = 0;
        ps_cnt = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clkin);
            hi += int'(pwm[0]);
            if (k < PERIOD) ps_cnt += int'(period_start);
        end
        check("idle_high_cycles", hi, 50);
        check("idle_no_ps_first_period", ps_cnt, 0);
        check("idle_ps_after_100", int'(period_start), 1);

        // Saturation upward
        for (int i = 1; i <= 6; i++) begin
            e = (50 + STEP * i > PERIOD) ? PERIOD : 50 + STEP * i;
            tbl.push_back('{name: $sformatf("sat_inc%0d", i), pi: 2'b01, pd: 2'b00, hold: 2, e0: e, e1: 50});
        end
        run_table();
        wait_ps(2 * PERIOD + 50);
        count_high(0, PERIOD, hi);
        check("sat_full_high", hi, PERIOD);

        // Saturation downward
        for (int i = 1; i <= 11; i++) begin
            e = (100 - STEP * i < 0) ? 0 : 100 - STEP * i;
            tbl.push_back('{name: $sformatf("sat_dec%0d", i), pi: 2'b00, pd: 2'b01, hold: 2, e0: e, e1: 50});
        end
        run_table();
        wait_ps(2 * PERIOD + 50);
        count_high(0, PERIOD, hi);
        check("sat_zero_low", hi, 0);

        // Simultaneous presses, long hold, channel 1 steps
        tbl.push_back('{name: "both_ch0",  pi: 2'b01, pd: 2'b01, hold: 2,   e0: 0,  e1: 50});
        tbl.push_back('{name: "hold_inc0", pi: 2'b01, pd: 2'b00, hold: 500, e0: 10, e1: 50});
        tbl.push_back('{name: "dec_ch1",   pi: 2'b00, pd: 2'b10, hold: 2,   e0: 10, e1: 40});
        tbl.push_back('{name: "inc_ch1",   pi: 2'b10, pd: 2'b00, hold: 1,   e0: 10, e1: 50});
        run_table();

        // Mid-period press on channel 1 at counter = 20
        wait_ps(2 * PERIOD + 50);
        hi = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clkin);
            hi += int'(pwm[1]);
            if (k == 20) inc[1] = 1'b0;
            if (k == 22) begin
                inc[1] = 1'b1;
                check("mid_d1_before", int'(d[2*WIDTH-1:WIDTH]), 50);
            end
            if (k == 23) check("mid_d1_after", int'(d[2*WIDTH-1:WIDTH]), 60);
        end
        check("mid_current_period_high", hi, 50);
        check("mid_boundary", int'(period_start), 1);
        count_high(1, PERIOD, hi);
        check("mid_next_period_high", hi, 60);

        // Centre-aligned switch requested mid-period
        wait_ps(2 * PERIOD + 50);
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clkin);
            if (k == 30) mode = 1'b1;
        end
        check("ctr_switch_at_edge_boundary", int'(period_start), 1);
        hi = 0;
        ps_cnt = 0;
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            @(negedge clkin);
            hs[k-1] = pwm[0];
            hi += int'(pwm[0]);
            if (k < 2 * PERIOD) ps_cnt += int'(period_start);
        end
        check("ctr_no_ps_inside", ps_cnt, 0);
        check("ctr_ps_after_200", int'(period_start), 1);
        check("ctr_high_cycles", hi, 2 * 10);
        asym = 0;
        for (int t = 0; t < 2 * PERIOD; t++) begin
            if (hs[t] != hs[2*PERIOD-1-t]) asym++;
        end
        check("ctr_symmetric_about_turn", asym, 0);

        // Reset mid-period at counter = 37
        mode = 1'b0;
        wait_ps(2 * PERIOD + 50);
        tick(37);
        reset = 1'b0;
        @(negedge clkin);
        check("rstmid_d0", int'(d[WIDTH-1:0]), 50);
        check("rstmid_d1", int'(d[2*WIDTH-1:WIDTH]), 50);
        check("rstmid_pwm", int'(pwm), 0);
        check("rstmid_period_start", int'(period_start), 0);
        reset = 1'b1;
        ps_cnt = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clkin);
            if (k < PERIOD) ps_cnt += int'(period_start);
        end
        check("rstmid_no_spurious_ps", ps_cnt, 0);
        check("rstmid_ps_after_100", int'(period_start), 1);

        // Randomised strobes and mode changes against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clkin);
            for (int c = 0; c < CHANNELS; c++) begin
                if ($urandom_range(0, 7) == 0) inc[c] = ~inc[c];
                if ($urandom_range(0, 7) == 0) dec[c] = ~dec[c];
            end
            if ($urandom_range(0, 299) == 0) mode = ~mode;
        end
        inc = '1;
        dec = '1;
        tick(5);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
